// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter.
//   tx_state_e : frame sequencer states
//   parity_e   : encoding of the parity_mode input (2'b11 is reserved and means no parity)
//   TX_IDLE    : level of the serial line when nothing is being sent
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  localparam logic TX_IDLE = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous active-high reset.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous reset; empties the FIFO
//   push   in   write wdata (ignored while full)
//   pop    in   consume the head entry (ignored while empty)
//   wdata  in   WIDTH  write data
//   rdata  out  WIDTH  head entry; valid whenever empty is low, so it is valid in the pop cycle
//   count  out  entries held, 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal TX FIFO.
// Frame: 1 start bit, DATA_BITS data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
// Every bit lasts one clken period.
// Ports:
//   clk_50m      in   system clock (posedge)
//   rst          in   synchronous active-high reset; aborts any frame in flight
//   clken        in   baud tick, one-cycle pulse per bit period (may be held high)
//   din          in   DATA_BITS  write data
//   wr_en        in   push din into the FIFO (dropped while full)
//   parity_mode  in   2  00 none, 01 even, 10 odd, 11 none
//   two_stop     in   1 = two stop bits
//   tx           out  serial line, idles high, registered
//   tx_busy      out  FIFO not empty or a frame in progress
//   full         out  FIFO full
//   fifo_count   out  CNT_W  queued entries, excluding the frame being sent
//   overflow     out  sticky: a write was attempted while full
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 clken,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 full,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 overflow
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int BPW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BPW-1:0] LAST_BIT = BPW'(DATA_BITS - 1);

  // Even parity makes the total count of ones even; odd parity makes it odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    parity_bit = odd ? ~^data : ^data;
  endfunction

  tx_state_e            state_q;
  logic                 tx_q;
  logic [BPW-1:0]       bitpos_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_en_q;
  logic                 par_odd_q;
  logic                 two_stop_q;
  logic                 overflow_q;

  logic [DATA_BITS-1:0] fifo_rdata;
  logic [FCW-1:0]       fifo_cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  // Writes are judged against the registered full flag only; a pop in the
  // same cycle does not make room for a write that arrives while full.
  assign push = wr_en && !fifo_full;
  // IDLE pops immediately, independent of clken, so back-to-back frames
  // lose no bit period between the last stop bit and the next start bit.
  assign pop  = (state_q == IDLE) && !fifo_empty;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_50m),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (din),
    .rdata (fifo_rdata),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx         = tx_q;
  assign tx_busy    = (state_q != IDLE) || !fifo_empty;
  assign full       = fifo_full;
  assign fifo_count = CNT_W'(fifo_cnt);
  assign overflow   = overflow_q;

  // Frame sequencer. Only IDLE->START ignores clken; every other transition
  // and every tx update happens on a clken cycle.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q  <= IDLE;
      tx_q     <= TX_IDLE;
      bitpos_q <= '0;
    end else if (pop) begin
      state_q <= START;
    end else if (clken) begin
      case (state_q)
        IDLE: begin
          tx_q <= TX_IDLE;
        end
        START: begin
          tx_q     <= 1'b0;
          bitpos_q <= '0;
          state_q  <= DATA;
        end
        DATA: begin
          tx_q <= data_q[bitpos_q];
          if (bitpos_q == LAST_BIT) begin
            state_q <= par_en_q ? PARITY : STOP1;
          end else begin
            bitpos_q <= bitpos_q + BPW'(1);
          end
        end
        PARITY: begin
          tx_q    <= parity_bit(data_q, par_odd_q);
          state_q <= STOP1;
        end
        STOP1: begin
          tx_q    <= TX_IDLE;
          state_q <= two_stop_q ? STOP2 : IDLE;
        end
        STOP2: begin
          tx_q    <= TX_IDLE;
          state_q <= IDLE;
        end
        default: begin
          tx_q    <= TX_IDLE;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Word and framing options are captured at the pop so that later changes
  // on din/parity_mode/two_stop cannot corrupt the frame in flight.
  always_ff @(posedge clk_50m) begin
    if (pop) begin
      data_q     <= fifo_rdata;
      par_en_q   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      par_odd_q  <= (parity_mode == PAR_ODD);
      two_stop_q <= two_stop;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (wr_en && fifo_full) begin
      overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: the stimulus side queues the frame each
// accepted word must produce; a monitor decodes the tx line on clken cycles and
// compares every received frame with the head of that queue.
module tb_uart_tx_fifo;

  localparam int DB    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_50m = 1'b0;
  logic          rst;
  logic          clken;
  logic [DB-1:0] din;
  logic          wr_en;
  logic [1:0]    parity_mode;
  logic          two_stop;
  logic          tx;
  logic          tx_busy;
  logic          full;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  uart_tx_fifo #(
    .DATA_BITS  (DB),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk_50m     (clk_50m),
    .rst         (rst),
    .clken       (clken),
    .din         (din),
    .wr_en       (wr_en),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .full        (full),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct {
    logic [15:0]   bits;
    int            len;
    logic [DB-1:0] word;
  } frame_t;

  frame_t exp_q[$];

  int n_chk = 0;
  int n_pass = 0;

  // Monitor state visible to the stimulus side
  bit mon_inf = 0;
  int mon_idx = 0;
  int frames_seen = 0;
  int idle_run = 0;
  int gap_max = 0;

  int ck_per = 0;
  int ck_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
  endtask

  // Reference frame: start, data LSB first, parity chosen so the total number
  // of ones is even (01) or odd (10), then one or two stop bits.
  function automatic frame_t make_frame(input logic [DB-1:0] d, input logic [1:0] pm,
                                        input logic ts);
    frame_t f;
    int n;
    int ones;
    f.bits = '0;
    f.word = d;
    n = 0;
    ones = $countones(d);
    f.bits[n] = 1'b0; n++;
    for (int i = 0; i < DB; i++) begin
      f.bits[n] = d[i]; n++;
    end
    if (pm == 2'b01) begin
      f.bits[n] = ((ones % 2) == 1); n++;
    end else if (pm == 2'b10) begin
      f.bits[n] = ((ones % 2) == 0); n++;
    end
    f.bits[n] = 1'b1; n++;
    if (ts) begin
      f.bits[n] = 1'b1; n++;
    end
    f.len = n;
    return f;
  endfunction

  task automatic queue_word(input logic [DB-1:0] d);
    exp_q.push_back(make_frame(d, parity_mode, two_stop));
  endtask

  // Caller is positioned at a negedge; returns at the following negedge.
  task automatic push_word(input logic [DB-1:0] d);
    din   = d;
    wr_en = 1'b1;
    @(negedge clk_50m);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string nm);
    int quiet;
    quiet = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_50m);
      if (!tx_busy && !mon_inf) quiet++;
      else quiet = 0;
      if (quiet >= 3) return;
    end
    n_chk++;
    $display("FAIL %s: idle timeout, tx_busy=%0b required 0", nm, tx_busy);
  endtask

  task automatic wait_bits(input int k, input int max_cyc, input string nm);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_50m);
      if (mon_inf && mon_idx >= k) return;
    end
    n_chk++;
    $display("FAIL %s: bit wait timeout, bits seen=%0d required %0d", nm, mon_idx, k);
  endtask

  // Baud tick generator: period 0 = off, 1 = held high, N = one pulse every N clocks
  initial begin
    clken = 1'b0;
    forever begin
      @(negedge clk_50m);
      if (ck_per <= 0) begin
        clken  = 1'b0;
        ck_cnt = 0;
      end else begin
        ck_cnt++;
        if (ck_cnt >= ck_per) begin
          clken  = 1'b1;
          ck_cnt = 0;
        end else begin
          clken = 1'b0;
        end
      end
    end
  end

  // Monitor: samples tx just after each clock edge on which clken was high
  initial begin
    frame_t      cur;
    logic [15:0] got;
    logic [15:0] mask;
    logic        ck;
    logic        r;
    cur.bits = '0;
    cur.len  = 0;
    cur.word = '0;
    got = '0;
    forever begin
      @(posedge clk_50m);
      ck = clken;
      r  = rst;
      #1;
      if (r) begin
        mon_inf = 0;
        mon_idx = 0;
      end else if (ck) begin
        if (!mon_inf) begin
          if (tx === 1'b0) begin
            if (idle_run > gap_max) gap_max = idle_run;
            idle_run = 0;
            if (exp_q.size() == 0) begin
              n_chk++;
              $display("FAIL unexpected_frame: start bit seen with no frame queued");
            end else begin
              cur = exp_q.pop_front();
              got = '0;
              mon_inf = 1;
              mon_idx = 1;
            end
          end else begin
            idle_run++;
          end
        end else begin
          got[mon_idx] = tx;
          mon_idx++;
          if (mon_idx >= cur.len) begin
            mask = 16'((32'd1 << cur.len) - 32'd1);
            check($sformatf("frame_%02h_len%0d", cur.word, cur.len),
                  32'(got & mask), 32'(cur.bits & mask));
            frames_seen++;
            mon_inf = 0;
            mon_idx = 0;
          end
        end
      end
    end
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] w1;
    logic [DB-1:0] w2;
    int fs0;
    int nb;

    rst = 1'b1;
    wr_en = 1'b0;
    din = '0;
    parity_mode = 2'b00;
    two_stop = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clk_50m);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk_50m);

    // Basic 8N1, A5 with clken every 16 clocks
    ck_per = 16;
    @(negedge clk_50m);
    queue_word(8'hA5);
    push_word(8'hA5);
    wait_idle(600, "8n1_idle");
    check("8n1_busy", 32'(tx_busy), 32'd0);

    // 8E2 and 8O1 with 03
    parity_mode = 2'b01; two_stop = 1'b1;
    @(negedge clk_50m);
    queue_word(8'h03);
    push_word(8'h03);
    wait_idle(600, "8e2_idle");
    parity_mode = 2'b10; two_stop = 1'b0;
    @(negedge clk_50m);
    queue_word(8'h03);
    push_word(8'h03);
    wait_idle(600, "8o1_idle");
    check("par_drained", 32'(exp_q.size()), 32'd0);

    // First-frame latency with clken held high: write at N, tx low after N+2
    parity_mode = 2'b00; two_stop = 1'b0;
    ck_per = 1;
    repeat (2) @(negedge clk_50m);
    queue_word(8'h5A);
    push_word(8'h5A);
    check("lat_n_tx", 32'(tx), 32'd1);
    check("lat_n_busy", 32'(tx_busy), 32'd1);
    @(negedge clk_50m);
    check("lat_n1_tx", 32'(tx), 32'd1);
    @(negedge clk_50m);
    check("lat_n2_tx", 32'(tx), 32'd0);
    wait_idle(100, "lat_idle");

    // Fill with clken off. The first word is popped straight into the
    // sequencer, so 17 words are accepted and the 18th overflows.
    ck_per = 0;
    parity_mode = 2'($urandom_range(0, 3));
    two_stop = 1'($urandom_range(0, 1));
    repeat (3) @(negedge clk_50m);
    for (int i = 0; i < DEPTH + 2; i++) begin
      w1 = DB'($urandom);
      if (i < DEPTH + 1) queue_word(w1);
      push_word(w1);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(fifo_count), 32'd16);
    check("fill_overflow", 32'(overflow), 32'd1);
    check("fill_busy", 32'(tx_busy), 32'd1);
    fs0 = frames_seen;
    gap_max = 0;
    idle_run = 0;
    ck_per = 3;
    wait_idle(2000, "fill_idle");
    check("fill_frames", 32'(frames_seen - fs0), 32'(DEPTH + 1));
    check("fill_gap", 32'(gap_max), 32'd0);
    check("fill_ovf_sticky", 32'(overflow), 32'd1);
    check("fill_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk_50m);
    rst = 1'b1;
    @(negedge clk_50m);
    rst = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Parity change during DATA affects only the next frame
    ck_per = 4;
    parity_mode = 2'b00; two_stop = 1'b0;
    @(negedge clk_50m);
    w1 = DB'($urandom);
    w2 = DB'($urandom);
    exp_q.push_back(make_frame(w1, 2'b00, 1'b0));
    exp_q.push_back(make_frame(w2, 2'b01, 1'b0));
    push_word(w1);
    push_word(w2);
    wait_bits(4, 200, "cfg_bits");
    parity_mode = 2'b01;
    wait_idle(400, "cfg_idle");
    check("cfg_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a frame, then a clean frame
    parity_mode = 2'b00;
    @(negedge clk_50m);
    w1 = DB'($urandom);
    w2 = DB'($urandom);
    queue_word(w1);
    queue_word(w2);
    push_word(w1);
    push_word(w2);
    wait_bits(4, 200, "mid_bits");
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk_50m);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    rst = 1'b0;
    @(negedge clk_50m);
    w1 = DB'($urandom);
    queue_word(w1);
    push_word(w1);
    wait_idle(400, "mid_idle");
    check("mid_drained", 32'(exp_q.size()), 32'd0);

    // Random batches: random config, baud period and write spacing
    for (int b = 0; b < 6; b++) begin
      parity_mode = 2'($urandom_range(0, 3));
      two_stop = 1'($urandom_range(0, 1));
      ck_per = $urandom_range(1, 6);
      nb = $urandom_range(1, DEPTH);
      @(negedge clk_50m);
      for (int i = 0; i < nb; i++) begin
        w1 = DB'($urandom);
        queue_word(w1);
        push_word(w1);
        if ($urandom_range(0, 1) == 1) @(negedge clk_50m);
      end
      wait_idle(3000, "rnd_idle");
      check("rnd_count", 32'(fifo_count), 32'd0);
      check("rnd_overflow", 32'(overflow), 32'd0);
      check("rnd_drained", 32'(exp_q.size()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
